// File: rtl/pipe_pkg.sv
// Shared widths, control-bit indices and the bubble value for the elastic pipeline-stage registers.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 68;
    localparam int unsigned PIPE_CTRL_W = 4;

    localparam int unsigned CTRL_HLT      = 3;
    localparam int unsigned CTRL_MEMTOREG = 2;
    localparam int unsigned CTRL_REGWRITE = 1;
    localparam int unsigned CTRL_PCS      = 0;

    localparam logic [PIPE_CTRL_W-1:0] PIPE_CTRL_BUBBLE = '0;

    // Saturating increment for the 16-bit performance counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One entry of the stage: valid + data + ctrl. Kill clears valid and parks ctrl at the bubble value
// while the data register keeps its last contents.
module pipe_slot #(
    parameter int unsigned           DATA_W      = 68,
    parameter int unsigned           CTRL_W      = 4,
    parameter logic [CTRL_W-1:0]     CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              kill,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= CTRL_BUBBLE;
        end else if (kill) begin
            valid <= 1'b0;
            ctrl  <= CTRL_BUBBLE;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with 2-entry skid buffer, flush and bubble-safe control output.
// Optional perf counters (stall_cnt, flush_cnt) are built only when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = PIPE_DATA_W,
    parameter int unsigned       CTRL_W      = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = {CTRL_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data, s_data;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl;
    logic              m_load, m_kill, s_load, s_kill;
    logic [DATA_W-1:0] m_d_data;
    logic [CTRL_W-1:0] m_d_ctrl;
    logic              acc, take;

    assign in_ready  = ~s_valid;
    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_BUBBLE;

    assign acc  = in_valid & in_ready;
    assign take = m_valid & out_ready;

    // Main slot refills from the skid entry first so ordering stays FIFO.
    assign m_d_data = s_valid ? s_data : in_data;
    assign m_d_ctrl = s_valid ? s_ctrl : in_ctrl;

    always_comb begin
        m_load = 1'b0;
        m_kill = 1'b0;
        s_load = 1'b0;
        s_kill = 1'b0;
        if (flush) begin
            m_kill = 1'b1;
            s_kill = 1'b1;
        end else if (!m_valid || take) begin
            if (s_valid) begin
                m_load = 1'b1;
                s_kill = 1'b1;
            end else if (acc) begin
                m_load = 1'b1;
            end else begin
                m_kill = 1'b1;
            end
        end else if (acc) begin
            s_load = 1'b1;
        end
    end

    pipe_slot #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_main (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (m_load),
        .kill   (m_kill),
        .d_data (m_d_data),
        .d_ctrl (m_d_ctrl),
        .valid  (m_valid),
        .data   (m_data),
        .ctrl   (m_ctrl)
    );

    pipe_slot #(
        .DATA_W      (DATA_W),
        .CTRL_W      (CTRL_W),
        .CTRL_BUBBLE (CTRL_BUBBLE)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (s_load),
        .kill   (s_kill),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (s_valid),
        .data   (s_data),
        .ctrl   (s_ctrl)
    );

`ifdef PIPE_STAGE_PERF_EN
    logic [15:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 16'h0000;
            flush_q <= 16'h0000;
        end else begin
            if (m_valid && !out_ready && !flush)
                stall_q <= sat_inc16(stall_q);
            if (flush && (m_valid || s_valid || in_valid))
                flush_q <= sat_inc16(flush_q);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule
